keypad_entry: RTL

Front-end for the microwave timer's digit-load interface. Takes a raw 10-key numeric keypad plus a clear key, then synchronizes, validates and debounces each press. Each accepted press becomes one BCD digit with a single-cycle active-low load strobe, which shifts the digit into the timer's seconds-ones position. It counts entered digits, blocks entry beyond the timer's three-digit capacity, and produces a clear pulse for the timer.

---
 rtl/keypad_entry_if.sv | 22 ++
 rtl/keypad_entry.sv | 90 +++++++++
 2 files changed

// File: rtl/keypad_entry_if.sv
// keypad_entry_if: keypad-to-timer digit-load bus
// Signals: keys/clear_key raw keypad (async), lock timer-running (sync),
//   data BCD digit, loadn load strobe, tclrn clear strobe, digits count, key_err multi-key pulse
// master: keypad/timer side driving keys and lock; slave: keypad_entry
interface keypad_entry_if;
  logic [9:0] keys;
  logic       clear_key;
  logic       lock;
  logic [3:0] data;
  logic       loadn;
  logic       tclrn;
  logic [1:0] digits;
  logic       key_err;
  modport master (
    output keys, clear_key, lock,
    input  data, loadn, tclrn, digits, key_err
  );
  modport slave (
    input  keys, clear_key, lock,
    output data, loadn, tclrn, digits, key_err
  );
endinterface

// File: rtl/keypad_entry.sv
// keypad_entry: synchronizes, debounces and validates keypad presses into BCD digit loads for the timer
// Ports: clk rising-edge clock; clrn async active-low reset;
//   bus (keypad_entry_if.slave): keys/clear_key raw inputs, lock sync input,
//   data/loadn/tclrn/digits/key_err registered outputs
module keypad_entry #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MAX_DIGITS      = 3
) (
  input logic           clk,
  input logic           clrn,
  keypad_entry_if.slave bus
);
  typedef enum logic [1:0] {IDLE, PRESS, LOAD, RELEASE} state_t;
  localparam logic [3:0] NONE    = 4'hF;
  localparam logic [3:0] MULTI   = 4'hE;
  localparam logic [7:0] DB_MAX  = 8'(DEBOUNCE_CYCLES);
  localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [1:0] MAXD    = 2'(MAX_DIGITS);
  logic [9:0] r_k1, r_k2;
  logic       r_c1, r_c2, r_c3, r_cedge;
  logic [3:0] r_prev;
  logic [7:0] r_cnt;
  state_t     r_state;
  logic [3:0] r_data;
  logic [1:0] r_digits;
  logic       r_loadn, r_tclrn, r_key_err;
  logic [3:0] w_code, w_enc;
  logic       w_multi, w_stable, w_sat, w_clr, w_load, w_err;
  always_comb begin
    w_code = 4'd0;
    for (int i = 0; i < 10; i++) if (r_k2[i]) w_code = 4'(i);
  end
  // clearing the lowest set bit leaves something only when two or more keys are down
  assign w_multi  = |(r_k2 & (r_k2 - 10'd1));
  assign w_enc    = ~|r_k2 ? NONE : w_multi ? MULTI : w_code;
  // true on the edge where the counter reaches DEBOUNCE_CYCLES (or is already there)
  assign w_stable = (w_enc == r_prev) && (r_cnt >= DB_LAST);
  assign w_clr    = r_cedge & ~bus.lock;
  assign w_sat    = (r_state == PRESS) && (w_enc != NONE) && w_stable;
  // a clear in the saturation cycle discards the press entirely
  assign w_err    = w_sat & ~w_clr & (w_enc == MULTI);
  assign w_load   = w_sat & ~w_clr & (w_enc != MULTI) & ~bus.lock & (r_digits < MAXD);
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) begin
      r_k1    <= '0;
      r_k2    <= '0;
      r_c1    <= 1'b0;
      r_c2    <= 1'b0;
      r_c3    <= 1'b0;
      r_cedge <= 1'b0;
      r_prev  <= NONE;
      r_cnt   <= '0;
    end else begin
      r_k1    <= bus.keys;
      r_k2    <= r_k1;
      r_c1    <= bus.clear_key;
      r_c2    <= r_c1;
      r_c3    <= r_c2;
      r_cedge <= r_c2 & ~r_c3;
      r_prev  <= w_enc;
      r_cnt   <= (w_enc != r_prev) ? 8'd0 : (r_cnt < DB_MAX) ? r_cnt + 8'd1 : r_cnt;
    end
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) begin
      r_state   <= IDLE;
      r_data    <= 4'd0;
      r_digits  <= 2'd0;
      r_loadn   <= 1'b1;
      r_tclrn   <= 1'b1;
      r_key_err <= 1'b0;
    end else begin
      case (r_state)
        IDLE:    r_state <= (w_enc != NONE) ? PRESS : IDLE;
        PRESS:   r_state <= (w_enc == NONE) ? IDLE : w_load ? LOAD : w_stable ? RELEASE : PRESS;
        LOAD:    r_state <= RELEASE;
        RELEASE: r_state <= (w_enc == NONE && w_stable) ? IDLE : RELEASE;
      endcase
      r_loadn   <= ~w_load;
      r_tclrn   <= ~w_clr;
      r_key_err <= w_err;
      // a clear landing on the LOAD cycle zeroes the count after the increment
      r_data    <= w_clr ? 4'd0 : w_load ? w_enc : r_data;
      r_digits  <= w_clr ? 2'd0 : w_load ? r_digits + 2'd1 : r_digits;
    end
  assign bus.data    = r_data;
  assign bus.loadn   = r_loadn;
  assign bus.tclrn   = r_tclrn;
  assign bus.digits  = r_digits;
  assign bus.key_err = r_key_err;
endmodule
